// File: rtl/spmv_mem_responder.sv
// spmv_mem_responder: memory end of the spmv_pe request/response link, backed by an internal word RAM.
// Optional request checking and the sticky err_o output are enabled by `define SPMV_MEM_RSP_ERR_CHECK_EN.
module spmv_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_WIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_mem_ld_i,
  input  logic                 req_mem_st_i,
  input  logic [47:0]          req_mem_addr_i,
  input  logic [63:0]          req_mem_d_or_tag_i,
  output logic                 req_mem_stall_o,
  output logic                 rsp_mem_push_o,
  output logic [TAG_WIDTH-1:0] rsp_mem_tag_o,
  output logic [63:0]          rsp_mem_q_o,
`ifdef SPMV_MEM_RSP_ERR_CHECK_EN
  output logic                 err_o,
`endif
  input  logic                 rsp_mem_stall_i
);

  localparam int PIPE_LEN  = LATENCY - 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int RAM_WORDS = 1 << ADDR_WIDTH;

  logic [63:0]           ram_q [RAM_WORDS];
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic                  ldAccept;

  logic [PIPE_LEN-1:0]   pipeVld_q;
  logic [TAG_WIDTH-1:0]  pipeTag_q  [PIPE_LEN];
  logic [63:0]           pipeData_q [PIPE_LEN];

  logic [TAG_WIDTH-1:0]  fifoTag_q  [FIFO_DEPTH];
  logic [63:0]           fifoData_q [FIFO_DEPTH];
  logic [PTR_W:0]        wrPtr_q, wrPtr_d;
  logic [PTR_W:0]        rdPtr_q, rdPtr_d;
  logic                  fifoWr, fifoPop, headVld;

  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic                  push_q, push_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [63:0]           data_q, data_d;

  // Out-of-range addresses alias by truncation; the byte offset is ignored.
  assign wordIdx  = req_mem_addr_i[ADDR_WIDTH+2:3];
  assign ldAccept = req_mem_ld_i & ~req_mem_st_i & ~req_mem_stall_o;

  assign req_mem_stall_o = (outstanding_q == CNT_W'(FIFO_DEPTH));

  // Stores ignore stall; a load's RAM read happens at its accepting edge.
  always_ff @(posedge clk) begin
    if (req_mem_st_i) begin
      ram_q[wordIdx] <= req_mem_d_or_tag_i;
    end
    if (ldAccept) begin
      pipeData_q[0] <= ram_q[wordIdx];
      pipeTag_q[0]  <= req_mem_d_or_tag_i[TAG_WIDTH-1:0];
    end
    for (int k = 1; k < PIPE_LEN; k++) begin
      pipeData_q[k] <= pipeData_q[k-1];
      pipeTag_q[k]  <= pipeTag_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipeVld_q <= '0;
    end else begin
      pipeVld_q[0] <= ldAccept;
      for (int k = 1; k < PIPE_LEN; k++) begin
        pipeVld_q[k] <= pipeVld_q[k-1];
      end
    end
  end

  // Credit accounting guarantees the FIFO has room for every pipeline entry.
  assign fifoWr  = pipeVld_q[PIPE_LEN-1];
  assign headVld = (wrPtr_q != rdPtr_q);
  assign fifoPop = headVld & ~rsp_mem_stall_i;

  always_ff @(posedge clk) begin
    if (fifoWr) begin
      fifoTag_q[wrPtr_q[PTR_W-1:0]]  <= pipeTag_q[PIPE_LEN-1];
      fifoData_q[wrPtr_q[PTR_W-1:0]] <= pipeData_q[PIPE_LEN-1];
    end
  end

  always_comb begin
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    outstanding_d = outstanding_q;
    push_d        = fifoPop;
    tag_d         = tag_q;
    data_d        = data_q;
    if (fifoWr) begin
      wrPtr_d = wrPtr_q + (PTR_W+1)'(1);
    end
    if (fifoPop) begin
      rdPtr_d = rdPtr_q + (PTR_W+1)'(1);
      tag_d   = fifoTag_q[rdPtr_q[PTR_W-1:0]];
      data_d  = fifoData_q[rdPtr_q[PTR_W-1:0]];
    end
    if (ldAccept && !fifoPop) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!ldAccept && fifoPop) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      outstanding_q <= '0;
      push_q        <= 1'b0;
      tag_q         <= '0;
      data_q        <= '0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      outstanding_q <= outstanding_d;
      push_q        <= push_d;
      tag_q         <= tag_d;
      data_q        <= data_d;
    end
  end

  assign rsp_mem_push_o = push_q;
  assign rsp_mem_tag_o  = tag_q;
  assign rsp_mem_q_o    = data_q;

`ifdef SPMV_MEM_RSP_ERR_CHECK_EN
  logic err_q, err_d;
  logic anyAccept, addrBad;

  assign anyAccept = ldAccept | req_mem_st_i;
  assign addrBad   = (req_mem_addr_i[2:0] != 3'd0) ||
                     (req_mem_addr_i[47:ADDR_WIDTH+3] != '0);

  always_comb begin
    err_d = err_q;
    if ((req_mem_ld_i && req_mem_st_i) ||
        (anyAccept && addrBad) ||
        (req_mem_ld_i && req_mem_stall_o)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unusedAddrBits;
  assign unusedAddrBits = ^{req_mem_addr_i[47:ADDR_WIDTH+3], req_mem_addr_i[2:0]};
`endif

endmodule

// File: tb/tb_spmv_mem_responder.sv
// tb_spmv_mem_responder: randomized scoreboard bench for spmv_mem_responder against a queue-based model.
// Also exercises err_o when SPMV_MEM_RSP_ERR_CHECK_EN is defined.
module tb_spmv_mem_responder;

  localparam int AW    = 16;
  localparam int LAT   = 8;
  localparam int DEPTH = 16;
  localparam int TW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld = 1'b0, st = 1'b0, rspStall = 1'b0;
  logic [47:0]   addr = '0;
  logic [63:0]   dt = '0;
  logic          reqStall, push;
  logic [TW-1:0] tag;
  logic [63:0]   q;
`ifdef SPMV_MEM_RSP_ERR_CHECK_EN
  logic          err;
`endif

  spmv_mem_responder #(
    .ADDR_WIDTH(AW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_WIDTH(TW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_mem_ld_i       (ld),
    .req_mem_st_i       (st),
    .req_mem_addr_i     (addr),
    .req_mem_d_or_tag_i (dt),
    .req_mem_stall_o    (reqStall),
    .rsp_mem_push_o     (push),
    .rsp_mem_tag_o      (tag),
    .rsp_mem_q_o        (q),
`ifdef SPMV_MEM_RSP_ERR_CHECK_EN
    .err_o              (err),
`endif
    .rsp_mem_stall_i    (rspStall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [63:0]   data;
    int            ready;
  } rsp_t;

  rsp_t          pendQ[$];
  rsp_t          checkQ[$];
  logic [63:0]   modelMem [int];
  int            edgeCnt = 0;
  int            compared = 0;
  int            mismatched = 0;
  bit            live = 1'b0;
  bit            expPush = 1'b0;
  bit            expStall = 1'b0;
  logic [TW-1:0] expTag = '0;
  logic [63:0]   expQ = '0;

  function automatic int wordOf(logic [47:0] a);
    return int'(a[AW+2:3]);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, act, exp, edgeCnt);
    end
  endtask

  // Reference model: a load becomes pushable LAT edges after acceptance, pushes leave
  // strictly in order at most one per edge, and only when the requester is not stalling.
  always @(posedge clk) begin
    rsp_t item;
    bit   stallBefore;
    edgeCnt++;
    if (rst) begin
      pendQ.delete();
      checkQ.delete();
      expPush  = 1'b0;
      expStall = 1'b0;
      expTag   = '0;
      expQ     = '0;
      live     = 1'b1;
    end else if (live) begin
      stallBefore = (pendQ.size() == DEPTH);
      expPush = 1'b0;
      if (pendQ.size() > 0 && pendQ[0].ready <= edgeCnt && !rspStall) begin
        item = pendQ.pop_front();
        checkQ.push_back(item);
        expPush = 1'b1;
        expTag  = item.tag;
        expQ    = item.data;
      end
      if (st) begin
        modelMem[wordOf(addr)] = dt;
      end else if (ld && !stallBefore) begin
        item.tag   = dt[TW-1:0];
        item.data  = modelMem.exists(wordOf(addr)) ? modelMem[wordOf(addr)] : 64'hx;
        item.ready = edgeCnt + LAT;
        pendQ.push_back(item);
      end
      expStall = (pendQ.size() == DEPTH);
    end
  end

  // Monitor: samples on the falling edge and retires scoreboard entries as the DUT pushes.
  always @(negedge clk) begin
    rsp_t item;
    if (live) begin
      checkOutput("push", {63'd0, push}, {63'd0, expPush});
      if (push) begin
        if (checkQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_push: got tag 0x%0h q 0x%0h, required no push (edge %0d)",
                   tag, q, edgeCnt);
        end else begin
          item = checkQ.pop_front();
          checkOutput("rsp_tag", {61'd0, tag}, {61'd0, item.tag});
          checkOutput("rsp_q", q, item.data);
        end
      end else begin
        checkOutput("hold_tag", {61'd0, tag}, {61'd0, expTag});
        checkOutput("hold_q", q, expQ);
      end
      checkOutput("req_stall", {63'd0, reqStall}, {63'd0, expStall});
    end
  end

  task automatic applyStimulus(input bit l, input bit s, input logic [47:0] a,
                               input logic [63:0] d, input bit rs);
    ld       = l;
    st       = s;
    addr     = a;
    dt       = d;
    rspStall = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget = 0;
    while ((pendQ.size() != 0 || checkQ.size() != 0) && budget < 300) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      budget++;
    end
    if (pendQ.size() != 0 || checkQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: got %0d responses outstanding, required 0", pendQ.size() + checkQ.size());
    end
  endtask

  initial begin
    int          lat;
    int          w;
    int          r;
    logic [47:0] a;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single store then tagged load, with explicit latency measurement.
    applyStimulus(1'b0, 1'b1, 48'h40, 64'h3FF0000000000000, 1'b0);
    applyStimulus(1'b1, 1'b0, 48'h40, 64'd5, 1'b0);
    ld = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (push) begin
        lat = k;
        break;
      end
    end
    checkOutput("load_latency", 64'(lat), 64'(LAT));
    drain();

    // Fill words 0..31, then 20 back-to-back loads.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 48'(i * 8), {$urandom, $urandom}, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 48'(i * 8), 64'(i % 8), 1'b0);
    end
    drain();

    // Requester stalled: credit runs out after 16 accepts.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b1, 1'b0, 48'((i % 32) * 8), 64'(i % 8), 1'b1);
    end
    checkOutput("stall_full", {63'd0, reqStall}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 48'((i % 32) * 8), 64'(i % 8), 1'b0);
    end
    drain();

    // Toggled response stall with loads every cycle.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, 48'(((i * 5) % 32) * 8), 64'(i % 8), i[0]);
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, i[0]);
    end
    drain();

    // Reset with loads in flight; a pre-reset store must survive.
    applyStimulus(1'b0, 1'b1, 48'h140, 64'hDEAD_BEEF_0123_4567, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 48'(i * 8), 64'(i), 1'b0);
    end
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 48'h140, 64'd6, 1'b0);
    drain();

    // Randomized traffic with aliasing, odd byte offsets and random response stall.
    for (int i = 0; i < 400; i++) begin
      w = $urandom_range(0, 31);
      a = 48'(w) << 3;
      if ($urandom_range(0, 3) == 0) a[2:0] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a[47:AW+3] = 29'($urandom);
      r = $urandom_range(0, 9);
      if (r < 5) begin
        applyStimulus(1'b1, 1'b0, a, 64'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      end else if (r < 8) begin
        applyStimulus(1'b0, 1'b1, a, {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
      end else if (r == 8) begin
        applyStimulus(1'b1, 1'b1, a, {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
      end else begin
        applyStimulus(1'b0, 1'b0, '0, '0, ($urandom_range(0, 3) == 0));
      end
    end
    drain();

`ifdef SPMV_MEM_RSP_ERR_CHECK_EN
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    checkOutput("err_reset", {63'd0, err}, 64'd0);
    applyStimulus(1'b1, 1'b1, 48'h8, 64'h0BAD_CAFE_0000_0008, 1'b0);
    checkOutput("err_set", {63'd0, err}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    end
    checkOutput("err_sticky", {63'd0, err}, 64'd1);
    applyStimulus(1'b1, 1'b0, 48'h8, 64'd3, 1'b0);
    drain();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    checkOutput("err_cleared", {63'd0, err}, 64'd0);
`endif

    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
